qam_sample_deserializer: RTL and testbench
==========================================

Name: qam_sample_deserializer

Overview:
Downstream consumer of the QAM modulator's serial output. It accepts the serial sample bit plus the per-word frame-marker bit, locks onto word boundaries and rebuilds parallel WIDTH-bit samples. It delivers each sample on a valid/ready output register and reports lock status, misalignment and overflow. It replaces ad-hoc bench deserialization and feeds the DAC/sample-capture stage.

Parameters:
WIDTH, 8, bits per sample word (>=2)
MAX_MISS, 3, consecutive missing frame markers tolerated while locked before dropping lock (>=1)
MSB_FIRST, 0, 0 = first serial bit is sample bit 0; 1 = first serial bit is sample bit WIDTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
bit_in  in  1  serial sample bit, one per clk
sync_in  in  1  frame marker, high on the cycle carrying the first bit of a word
sample_out  out  WIDTH  reassembled sample
sample_valid  out  1  sample_out holds an unconsumed word
sample_ready  in  1  consumer accepts the word when sample_valid & sample_ready
locked  out  1  high while in LOCKED state
sync_err  out  1  one-cycle pulse: marker arrived at an unexpected bit position
overflow  out  1  one-cycle pulse: completed word dropped because the output was still full

Behaviour:
- Reset (rst=1 at an edge): state=HUNT, bit_cnt=0, miss_cnt=0, shift reg=0, sample_out=0, sample_valid=0, locked=0, sync_err=0, overflow=0. Reset mid-word discards the partial word and any held sample.
- HUNT: bit_in ignored until sync_in=1. On that edge: capture bit_in as the first bit, bit_cnt=1, miss_cnt=0, go LOCKED.
- LOCKED: capture bit_in each cycle at position bit_cnt, with order set by MSB_FIRST.
  - bit_cnt increments and wraps WIDTH-1 -> 0.
- Expected boundary (LOCKED, bit_cnt==0):
  - sync_in=1: miss_cnt=0.
  - sync_in=0: miss_cnt+1, and flywheel capture continues.
  - If the increment makes miss_cnt==MAX_MISS: go HUNT, drop that bit, bit_cnt=0, miss_cnt=0, locked falls next cycle.
- Unexpected marker (LOCKED, sync_in=1, bit_cnt!=0):
  - sync_err=1 for one cycle.
  - Partial word discarded; no sample emitted for it.
  - Realign: current bit is bit 0, bit_cnt=1, miss_cnt=0. Stays LOCKED.
- Word completion: the edge capturing position WIDTH-1 completes the word.
  - If sample_valid=0, or sample_valid & sample_ready on that edge: sample_out=word and sample_valid=1 after that edge. Latency is 0 cycles after the last bit edge.
  - Otherwise the new word is dropped, the held word is preserved and overflow pulses for one cycle.
- Output handshake:
  - sample_valid clears on an edge with sample_ready=1 when no new word completes.
  - sample_out is stable while sample_valid=1 and not accepted.
  - Back-to-back words with sample_ready tied high give one sample_valid-high cycle every WIDTH cycles.
- Simultaneous events:
  - A marker at bit_cnt==0 is a normal boundary, not an error.
  - The completion edge and the marker edge never coincide (position WIDTH-1 vs 0).
  - rst dominates everything.
- locked=1 exactly while state==LOCKED (registered).

Decomposition:
- Shared package qam_pkg holds:
  - state enum (HUNT, LOCKED)
  - default sample width constant (8), shared with the modulator
  - default MAX_MISS constant
- Natural sub-module: qam_sync_tracker. It owns the state, bit_cnt, miss_cnt and sync_err, and emits capture position, word_done and a realign strobe.
- The parent holds the shift register, output register, handshake and overflow.

Test Plan:
- Reset then HUNT: bit_in toggling, sync_in=0 for 50 cycles -> locked=0, sample_valid never 1, sample_out=0.
- Single word LSB-first: 0xA5 sent as bits 1,0,1,0,0,1,0,1 with sync_in on the first bit, sample_ready=1 -> sample_valid high for exactly one cycle after the 8th bit edge, sample_out=0xA5, locked=1.
- Stream 0x00,0xFF,0x3C with markers every 8 cycles, ready=1 -> three samples in order, each 8 cycles apart, sync_err=0, overflow=0.
- Early marker at bit_cnt=5 -> sync_err pulse for 1 cycle, no sample for the broken word, next word after realign assembled correctly.
- sample_ready=0 across two completed words 0x11 then 0x22 -> sample_out stays 0x11, overflow pulses once at the 0x22 completion, asserting ready consumes 0x11.
- Markers removed after lock, MAX_MISS=3 -> words 1-2 still emitted by flywheel, locked drops at the third missed boundary. Then rst asserted mid-word -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared definitions for the QAM sample path (modulator and deserializer).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qam_pkg;

    // Word-alignment state of the deserializer.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } qam_state_e;

    // Default sample word width, shared with the modulator.
    localparam int QAM_SAMPLE_WIDTH = 8;

    // Default number of consecutive missing markers tolerated while locked.
    localparam int QAM_MAX_MISS = 3;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int qam_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qam_sync_tracker.sv
// Word-boundary tracker: follows frame markers, keeps bit position and miss count.
// Latency: capture/word_done are combinational on the current cycle; state, locked, sync_err registered.
// Backpressure: none; one bit is consumed every cycle regardless of downstream state.
//
// Ports: clk/rst (sync, active-high), sync_i frame marker; cap_en_o/cap_pos_o say whether
// and where the current serial bit lands, word_done_o flags the last bit of a word,
// realign_o flags a fresh word start that discards any partial word, locked_o/sync_err_o
// are the registered status outputs.
module qam_sync_tracker
    import qam_pkg::*;
#(
    parameter int WIDTH    = QAM_SAMPLE_WIDTH,
    parameter int MAX_MISS = QAM_MAX_MISS,
    localparam int CW      = qam_cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync_i,
    output logic          cap_en_o,
    output logic [CW-1:0] cap_pos_o,
    output logic          word_done_o,
    output logic          realign_o,
    output logic          locked_o,
    output logic          sync_err_o
);

    localparam int MW = qam_cnt_w(MAX_MISS + 1);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
    localparam logic [MW-1:0] MISS_LIM = MW'(MAX_MISS);

    qam_state_e    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic          sync_err_q, sync_err_d;
    logic [MW-1:0] miss_inc;

    assign miss_inc = miss_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        sync_err_d  = 1'b0;
        cap_en_o    = 1'b0;
        cap_pos_o   = bit_cnt_q;
        word_done_o = 1'b0;
        realign_o   = 1'b0;

        case (state_q)
            HUNT: begin
                if (sync_i) begin
                    state_d    = LOCKED;
                    cap_en_o   = 1'b1;
                    cap_pos_o  = '0;
                    realign_o  = 1'b1;
                    bit_cnt_d  = CW'(1);
                    miss_cnt_d = '0;
                end
            end

            LOCKED: begin
                if (bit_cnt_q == '0) begin
                    // Expected boundary: a missing marker is tolerated (flywheel)
                    // until the miss budget runs out, then that bit is dropped.
                    if (sync_i) begin
                        miss_cnt_d = '0;
                        cap_en_o   = 1'b1;
                        bit_cnt_d  = CW'(1);
                    end else if (miss_inc == MISS_LIM) begin
                        state_d    = HUNT;
                        bit_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                        cap_en_o   = 1'b1;
                        bit_cnt_d  = CW'(1);
                    end
                end else if (sync_i) begin
                    // Marker mid-word: the transmitter restarted; adopt its framing.
                    sync_err_d = 1'b1;
                    cap_en_o   = 1'b1;
                    cap_pos_o  = '0;
                    realign_o  = 1'b1;
                    bit_cnt_d  = CW'(1);
                    miss_cnt_d = '0;
                end else begin
                    cap_en_o    = 1'b1;
                    word_done_o = (bit_cnt_q == LAST_POS);
                    bit_cnt_d   = (bit_cnt_q == LAST_POS) ? '0 : bit_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign locked_o   = (state_q == LOCKED);
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/qam_sample_deserializer.sv
// Rebuilds WIDTH-bit samples from the modulator's serial bit + frame-marker stream.
// Latency: sample_valid rises on the same edge that captures the last bit of a word.
// Backpressure: one-deep output register; a word completing while it is still full is dropped and overflow pulses.
//
// Ports: clk/rst (sync, active-high); bit_in/sync_in serial input; sample_out/sample_valid/
// sample_ready valid-ready output; locked, sync_err, overflow status.
module qam_sample_deserializer
    import qam_pkg::*;
#(
    parameter int WIDTH     = QAM_SAMPLE_WIDTH,
    parameter int MAX_MISS  = QAM_MAX_MISS,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             sync_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             locked,
    output logic             sync_err,
    output logic             overflow
);

    localparam int CW = qam_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic          cap_en;
    logic [CW-1:0] cap_pos;
    logic          word_done;
    logic          realign;
    logic [CW-1:0] bit_idx;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    qam_sync_tracker #(
        .WIDTH    (WIDTH),
        .MAX_MISS (MAX_MISS)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .sync_i      (sync_in),
        .cap_en_o    (cap_en),
        .cap_pos_o   (cap_pos),
        .word_done_o (word_done),
        .realign_o   (realign),
        .locked_o    (locked),
        .sync_err_o  (sync_err)
    );

    assign bit_idx = MSB_FIRST ? (LAST_POS - cap_pos) : cap_pos;

    // shift_d is also the completed word on a word_done cycle, so the sample
    // is available on the very edge that captures its last bit.
    always_comb begin
        shift_d = shift_q;
        if (realign) begin
            shift_d = '0;
        end
        if (cap_en) begin
            shift_d[bit_idx] = bit_in;
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        if (word_done) begin
            if (!valid_q || sample_ready) begin
                out_d   = shift_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_qam_sample_deserializer.sv
// Directed bench for qam_sample_deserializer (WIDTH=8, MAX_MISS=3, LSB first).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_qam_sample_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       sync_in;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       sample_ready;
    logic       locked;
    logic       sync_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qam_sample_deserializer #(
        .WIDTH     (8),
        .MAX_MISS  (3),
        .MSB_FIRST (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .sync_in      (sync_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .sync_err     (sync_err),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends bits first..last of d (LSB first); marker on bit 0 when mark is set.
    // Counts cycles with sample_valid / sync_err / overflow high after each edge.
    task automatic send_word(input logic [7:0] d, input logic mark, input int first,
                             input int last, output int vcnt, output int ecnt,
                             output int ocnt);
        vcnt = 0;
        ecnt = 0;
        ocnt = 0;
        for (int i = first; i <= last; i++) begin
            bit_in  = d[i[2:0]];
            sync_in = mark && (i == 0);
            tick();
            if (sample_valid) vcnt++;
            if (sync_err)     ecnt++;
            if (overflow)     ocnt++;
        end
        sync_in = 1'b0;
    endtask

    initial begin
        int vc, ec, oc;
        int lseen, vseen;
        logic [7:0] stream [3];
        stream[0] = 8'h00;
        stream[1] = 8'hFF;
        stream[2] = 8'h3C;

        rst = 1'b1;
        bit_in = 1'b0;
        sync_in = 1'b0;
        sample_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_locked",   32'(locked),       32'h0);
        check("rst_valid",    32'(sample_valid), 32'h0);
        check("rst_out",      32'(sample_out),   32'h0);
        check("rst_sync_err", 32'(sync_err),     32'h0);
        check("rst_overflow", 32'(overflow),     32'h0);
        rst = 1'b0;

        // HUNT ignores data without markers
        lseen = 0;
        vseen = 0;
        for (int i = 0; i < 50; i++) begin
            bit_in = i[0];
            tick();
            if (locked) lseen++;
            if (sample_valid) vseen++;
        end
        check("hunt_locked_cycles", 32'(lseen), 32'h0);
        check("hunt_valid_cycles",  32'(vseen), 32'h0);
        check("hunt_out",           32'(sample_out), 32'h0);

        // Single word 0xA5, LSB first
        send_word(8'hA5, 1'b1, 0, 7, vc, ec, oc);
        check("a5_valid_cycles", 32'(vc), 32'h1);
        check("a5_valid_last",   32'(sample_valid), 32'h1);
        check("a5_out",          32'(sample_out), 32'hA5);
        check("a5_locked",       32'(locked), 32'h1);

        // Back-to-back stream, one valid cycle per 8-bit word
        for (int w = 0; w < 3; w++) begin
            send_word(stream[w], 1'b1, 0, 7, vc, ec, oc);
            check("stream_valid_cycles", 32'(vc), 32'h1);
            check("stream_out",          32'(sample_out), 32'(stream[w]));
            check("stream_sync_err",     32'(ec), 32'h0);
            check("stream_overflow",     32'(oc), 32'h0);
        end

        // Early marker at bit_cnt=5: partial 0x5A is discarded, 0xC3 realigns
        send_word(8'h5A, 1'b1, 0, 4, vc, ec, oc);
        check("partial_valid_cycles", 32'(vc), 32'h0);
        check("partial_sync_err",     32'(ec), 32'h0);
        send_word(8'hC3, 1'b1, 0, 7, vc, ec, oc);
        check("realign_sync_err_cycles", 32'(ec), 32'h1);
        check("realign_valid_cycles",    32'(vc), 32'h1);
        check("realign_out",             32'(sample_out), 32'hC3);

        // Backpressure: 0x11 held, 0x22 dropped with one overflow pulse
        send_word(8'h11, 1'b1, 0, 7, vc, ec, oc);
        check("bp_first_out", 32'(sample_out), 32'h11);
        sample_ready = 1'b0;
        send_word(8'h22, 1'b1, 0, 7, vc, ec, oc);
        check("bp_valid_cycles",   32'(vc), 32'h8);
        check("bp_overflow_count", 32'(oc), 32'h1);
        check("bp_overflow_now",   32'(overflow), 32'h1);
        check("bp_out_held",       32'(sample_out), 32'h11);

        // Accept the held word on the first bit of 0x77
        sample_ready = 1'b1;
        bit_in = 1'b1;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("bp_consume_valid",    32'(sample_valid), 32'h0);
        check("bp_consume_overflow", 32'(overflow), 32'h0);
        send_word(8'h77, 1'b1, 1, 7, vc, ec, oc);
        check("after_bp_valid_cycles", 32'(vc), 32'h1);
        check("after_bp_out",          32'(sample_out), 32'h77);

        // Markers removed: two flywheel words, lock lost at third boundary
        send_word(8'h81, 1'b0, 0, 7, vc, ec, oc);
        check("fly1_valid_cycles", 32'(vc), 32'h1);
        check("fly1_out",          32'(sample_out), 32'h81);
        send_word(8'h42, 1'b0, 0, 7, vc, ec, oc);
        check("fly2_valid_cycles", 32'(vc), 32'h1);
        check("fly2_out",          32'(sample_out), 32'h42);
        check("fly2_locked",       32'(locked), 32'h1);
        bit_in = 1'b1;
        tick();
        check("miss3_locked", 32'(locked), 32'h0);
        check("miss3_valid",  32'(sample_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bit_in = i[0];
            tick();
        end

        // Relock, hold 0x99 unconsumed, then reset mid-word
        sample_ready = 1'b0;
        send_word(8'h99, 1'b1, 0, 7, vc, ec, oc);
        check("relock_out",    32'(sample_out), 32'h99);
        check("relock_valid",  32'(sample_valid), 32'h1);
        check("relock_locked", 32'(locked), 32'h1);
        send_word(8'h0F, 1'b1, 0, 2, vc, ec, oc);
        rst = 1'b1;
        tick();
        check("midrst_out",      32'(sample_out), 32'h0);
        check("midrst_valid",    32'(sample_valid), 32'h0);
        check("midrst_locked",   32'(locked), 32'h0);
        check("midrst_sync_err", 32'(sync_err), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;

        // Back in HUNT: unmarked data must not lock
        lseen = 0;
        vseen = 0;
        for (int i = 0; i < 10; i++) begin
            bit_in = 1'b1;
            tick();
            if (locked) lseen++;
            if (sample_valid) vseen++;
        end
        check("post_rst_locked_cycles", 32'(lseen), 32'h0);
        check("post_rst_valid_cycles",  32'(vseen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
